// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
package regfile_pkg;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;

    typedef struct packed {
        logic            full;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_slot_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_CSR  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant over the full writeback slots. RR_ARB_EN selects round-robin
// starting at ptr; without it the lowest requesting index always wins.
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]         req,
`ifdef RR_ARB_EN
    input  logic [$clog2(NREQ)-1:0] ptr,
`endif
    output logic [NREQ-1:0]         grant
);

`ifdef RR_ARB_EN
    int unsigned idx;

    always_comb begin
        grant = '0;
        idx   = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            idx = (32'(ptr) + off) % NREQ;
            if (req[idx] && grant == '0) grant[idx] = 1'b1;
        end
    end
`else
    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req[i] && grant == '0) grant[i] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single-write-port arbiter for the 32x32 register file: one buffered write per
// source, at most one commit per cycle, x0 writes dropped. RR_ARB_EN = round-robin.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = regfile_pkg::XLEN,
    parameter int AW   = regfile_pkg::AW
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      REQ_VLD,
    output logic [NREQ-1:0]      REQ_RDY,
    input  logic [NREQ*AW-1:0]   REQ_ADDR,
    input  logic [NREQ*XLEN-1:0] REQ_DATA,
    output logic                 EN,
    output logic [AW-1:0]        WA,
    output logic [XLEN-1:0]      WD,
    output logic [31:0]          PEND,
    output logic                 BUSY
);
    import regfile_pkg::*;

    wb_slot_t [NREQ-1:0] slot_q, slot_d;
    logic [NREQ-1:0]     full, grant;
    logic [AW-1:0]       wa_q, wa_d;
    logic [XLEN-1:0]     wd_q, wd_d;
    logic [NREGS-1:0]    pend;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) full[i] = slot_q[i].full;
    end

`ifdef RR_ARB_EN
    localparam int PW = $clog2(NREQ);
    logic [PW-1:0] ptr_q, ptr_d;

    rr_arbiter #(.NREQ(NREQ)) u_arb (.req(full), .ptr(ptr_q), .grant(grant));

    always_comb begin
        ptr_d = ptr_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) ptr_d = PW'((i + 1) % NREQ);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    rr_arbiter #(.NREQ(NREQ)) u_arb (.req(full), .grant(grant));
`endif

    assign REQ_RDY = ~full | grant;
    assign BUSY    = |full;
    assign EN      = |grant;

    // A granted slot may be refilled on the same edge it drains.
    always_comb begin
        slot_d = slot_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) slot_d[i].full = 1'b0;
            if (REQ_VLD[i] && REQ_RDY[i] && REQ_ADDR[i*AW +: AW] != '0) begin
                slot_d[i].full = 1'b1;
                slot_d[i].addr = REQ_ADDR[i*AW +: AW];
                slot_d[i].data = REQ_DATA[i*XLEN +: XLEN];
            end
        end
    end

    // WA/WD hold the last granted values while idle.
    always_comb begin
        wa_d = wa_q;
        wd_d = wd_q;
        pend = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                wa_d = slot_q[i].addr;
                wd_d = slot_q[i].data;
            end
            if (slot_q[i].full) pend[slot_q[i].addr] = 1'b1;
        end
    end

    assign WA   = wa_d;
    assign WD   = wd_d;
    assign PEND = pend;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            slot_q <= '0;
            wa_q   <= '0;
            wd_q   <= '0;
        end else begin
            slot_q <= slot_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural register file on the
// write port; expectations depend on whether RR_ARB_EN is defined.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NREQ = 3;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [NREQ-1:0]      REQ_VLD;
    logic [NREQ-1:0]      REQ_RDY;
    logic [NREQ*AW-1:0]   REQ_ADDR;
    logic [NREQ*XLEN-1:0] REQ_DATA;
    logic                 EN;
    logic [AW-1:0]        WA;
    logic [XLEN-1:0]      WD;
    logic [31:0]          PEND;
    logic                 BUSY;

    int checks   = 0;
    int failures = 0;
    int en_cnt   = 0;
    int n;
    int first;
    logic [XLEN-1:0] rf [NREGS];

    regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VLD(REQ_VLD), .REQ_RDY(REQ_RDY),
        .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
        .EN(EN), .WA(WA), .WD(WD), .PEND(PEND), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Register file model: x0 is hard-wired to zero.
    always @(posedge CLK) begin
        if (EN === 1'b1) begin
            en_cnt <= en_cnt + 1;
            if (WA != '0) rf[WA] <= WD;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int unsigned i, input logic v,
                           input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        REQ_VLD[i]              = v;
        REQ_ADDR[i*AW +: AW]    = a;
        REQ_DATA[i*XLEN +: XLEN] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0]  exp_wa   [3];
        logic [31:0]    exp_pend [3];
        exp_wa   = '{5'd4, 5'd8, 5'd12};
        exp_pend = '{32'h1110, 32'h1100, 32'h1000};

        for (int i = 0; i < NREGS; i++) rf[i] = '0;
        RST      = 1'b1;
        REQ_VLD  = '0;
        REQ_ADDR = '0;
        REQ_DATA = '0;
        repeat (2) step();
        check("rst_en",   EN,      0);
        check("rst_pend", PEND,    0);
        check("rst_busy", BUSY,    0);
        check("rst_rdy",  REQ_RDY, 3'b111);
        check("rst_wa",   WA,      0);
        check("rst_wd",   WD,      0);
        RST = 1'b0;
        step();

        // Single ALU write
        set_req(WB_ALU, 1'b1, 5'd7, 32'd140);
        step();
        REQ_VLD = '0;
        check("single_en",   EN,   1);
        check("single_wa",   WA,   7);
        check("single_wd",   WD,   140);
        check("single_pend", PEND, 32'h80);
        check("single_busy", BUSY, 1);
        step();
        check("single_rf7",  rf[7], 140);
        check("single_idle", EN,    0);
        check("single_pend0", PEND, 0);
        check("single_wa_hold", WA, 7);

        // Write to x0 from the load unit
        set_req(WB_LOAD, 1'b1, 5'd0, 32'd25);
        check("x0_rdy", REQ_RDY[1], 1);
        n = en_cnt;
        step();
        REQ_VLD = '0;
        check("x0_en",   EN,   0);
        check("x0_pend", PEND, 0);
        check("x0_busy", BUSY, 0);
        step();
        check("x0_no_write", en_cnt - n, 0);
        check("x0_rf0", rf[0], 0);

        // Reset with slots 0 and 1 full
        set_req(WB_ALU,  1'b1, 5'd5, 32'd55);
        set_req(WB_LOAD, 1'b1, 5'd6, 32'd66);
        step();
        REQ_VLD = '0;
        check("mid_busy", BUSY, 1);
        check("mid_pend", PEND, 32'h60);
        #2 RST = 1'b1;
        #1;
        check("mid_rst_en",   EN,      0);
        check("mid_rst_pend", PEND,    0);
        check("mid_rst_rdy",  REQ_RDY, 3'b111);
        n = en_cnt;
        step();
        #2 RST = 1'b0;
        repeat (3) step();
        check("mid_no_write", en_cnt - n, 0);
        check("mid_rf5", rf[5], 0);
        check("mid_rf6", rf[6], 0);

        // Three-way contention on one edge
        set_req(WB_ALU,  1'b1, 5'd4,  32'd40);
        set_req(WB_LOAD, 1'b1, 5'd8,  32'd80);
        set_req(WB_CSR,  1'b1, 5'd12, 32'd120);
        step();
        REQ_VLD = '0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("cont_en%0d", k),   EN,   1);
            check($sformatf("cont_wa%0d", k),   WA,   exp_wa[k]);
            check($sformatf("cont_wd%0d", k),   WD,   32'(exp_wa[k]) * 10);
            check($sformatf("cont_pend%0d", k), PEND, exp_pend[k]);
            step();
        end
        check("cont_idle", EN,   0);
        check("cont_pend", PEND, 0);
        check("cont_rf4",  rf[4],  40);
        check("cont_rf8",  rf[8],  80);
        check("cont_rf12", rf[12], 120);

        // ALU holds VLD while CSR writes once
        set_req(WB_ALU, 1'b1, 5'd3, 32'd33);
        set_req(WB_CSR, 1'b1, 5'd9, 32'd99);
        step();
        REQ_VLD[2] = 1'b0;
        first = 0;
        for (int c = 1; c <= 4; c++) begin
            if (EN === 1'b1 && WA == 5'd9 && first == 0) first = c;
            if (c < 4) step();
        end
`ifdef RR_ARB_EN
        check("rr_wait", first, 2);
        REQ_VLD[0] = 1'b0;
`else
        check("fixed_starve", first, 0);
        REQ_VLD[0] = 1'b0;
        for (int d = 1; d <= 4; d++) begin
            step();
            if (EN === 1'b1 && WA == 5'd9 && first == 0) first = d;
        end
        check("fixed_wait", first, 1);
`endif
        repeat (4) step();
        check("fair_busy", BUSY, 0);
        check("fair_rf9",  rf[9], 99);
        check("fair_rf3",  rf[3], 33);

        // Uncontested ALU stream
        n = en_cnt;
        for (int i = 1; i <= 7; i++) begin
            set_req(WB_ALU, 1'b1, AW'(i), XLEN'(i * 20));
            check($sformatf("b2b_rdy%0d", i), REQ_RDY[0], 1);
            step();
            check($sformatf("b2b_en%0d", i), EN, 1);
            check($sformatf("b2b_wa%0d", i), WA, i);
            check($sformatf("b2b_wd%0d", i), WD, i * 20);
        end
        REQ_VLD = '0;
        step();
        check("b2b_idle", EN, 0);
        check("b2b_count", en_cnt - n, 7);
        for (int i = 1; i <= 7; i++) check($sformatf("b2b_rf%0d", i), rf[i], i * 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
